tracer_stream: RTL
==================

// Module: tracer_stream
// PURPOSE
//  Downstream drain of the instruction tracer. Takes one completed trace step at a time.
//  Fetches its register-writeback and memory actions from the trace table over a
//  1-cycle synchronous read port. Serializes header and actions as a framed 64-bit
//  word stream (valid/ready) to the debug trace sink. One step per frame; o_tlast on the final word.
// PARAMETERS
//  TBL_ABITS  6   action index width
//  TBL_SZ     64  actions per step; must equal 2**TBL_ABITS; larger counts are clamped
// PORTS
//  i_clk         in   1   clock, all state on rising edge
//  i_rst         in   1   reset, asynchronous, active-high
//  i_step_valid  in   1   completed step offered
//  o_step_ready  out  1   step accepted when i_step_valid & o_step_ready
//  i_exec_cnt    in   64  step instruction counter
//  i_pc          in   64  step pc
//  i_instr       in   32  step opcode
//  i_regcnt      in   32  number of reg actions
//  i_memcnt      in   32  number of mem actions
//  o_rd_reg      out  1   reg-action table read strobe
//  o_rd_mem      out  1   mem-action table read strobe
//  o_rd_idx      out  TBL_ABITS  action index for the active read strobe
//  i_reg_waddr   in   6   reg action: writeback address (valid cycle after o_rd_reg)
//  i_reg_wres    in   64  reg action: written value
//  i_mem_flags   in   6   {store,size[1:0],complete,sc_release,ignored} (valid cycle after o_rd_mem)
//  i_mem_regaddr in   6   mem action writeback address
//  i_mem_addr    in   64  mem action address
//  i_mem_data    in   64  mem action data
//  o_tvalid      out  1   stream word valid
//  i_tready      in   1   sink accepts word
//  o_tdata       out  64  stream word
//  o_tlast       out  1   last word of frame
//  o_step_done   out  1   1-cycle pulse when last word of a frame is accepted
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE. o_step_ready=1; o_tvalid=0; o_tdata=0; o_tlast=0.
//   o_rd_reg=0; o_rd_mem=0; o_rd_idx=0; o_step_done=0. A partially sent frame is abandoned, not resumed.
//  o_step_ready=1 only in IDLE. On accept, latch all step fields.
//   Clamp: rc=min(i_regcnt,TBL_SZ), mc=min(i_memcnt,TBL_SZ); width TBL_ABITS+1.
//   Next state: HDR0.
//  States: IDLE, HDR0, HDR1, HDR2, REG_RD, REG_TAG, REG_VAL, MEM_RD, MEM_TAG, MEM_ADDR, MEM_DATA.
//  Emit states (HDRx, *_TAG, REG_VAL, MEM_ADDR, MEM_DATA): o_tvalid=1. Advance only on o_tvalid&i_tready.
//   o_tdata/o_tlast are registered and stable while stalled.
//  Word formats:
//   HDR0  = exec_cnt
//   HDR1  = pc
//   HDR2  = {instr, mc[15:0], rc[15:0]}
//   REG_TAG  = {8'h52, 50'h0, waddr}
//   REG_VAL  = wres
//   MEM_TAG  = {8'h4D, 44'h0, flags[5:0], regaddr}
//   MEM_ADDR = memaddr
//   MEM_DATA = data
//  Sequence: header, then rc reg actions (idx 0..rc-1), then mc mem actions (idx 0..mc-1).
//   Ignored mem actions are still emitted.
//  *_RD: assert strobe with o_rd_idx=idx for exactly one cycle. Next cycle, capture table data into
//   internal regs and enter *_TAG. Strobes are 0 in all other states.
//  Index counter resets to 0 when entering the reg phase and when entering the mem phase.
//  After REG_VAL: idx+1<rc -> REG_RD; else mc>0 -> MEM_RD (idx=0); else done.
//  After MEM_DATA: idx+1<mc -> MEM_RD; else done.
//  o_tlast=1 on the last word: HDR2 if rc=mc=0; REG_VAL if mc=0; otherwise final MEM_DATA.
//  On the accepted tlast word: o_step_done=1 that cycle, FSM -> IDLE. Next step acceptable the following cycle.
//  Max frame length: 3+2*TBL_SZ+3*TBL_SZ words. Counts above TBL_SZ never index out of range.
//  Data from the table is sampled only in the cycle after a strobe; other cycles are don't-care.
// TESTING
//  1 Step rc=0,mc=0, pc=0x80000000, tready=1
//    -> 3 words, HDR2={instr,0,0} with tlast; done pulse on 3rd word; step_ready high next cycle.
//  2 rc=2 (waddr 5,7; wres 0x11,0x22), mc=0
//    -> words: hdr×3, 0x52..05, 0x11, 0x52..07, 0x22 (tlast); reads at idx 0 then 1.
//  3 rc=0, mc=1 {store=1,size=3,ignored=1}, addr 0x1000, data 0xDEAD
//    -> MEM_TAG flags=6'b111001; 3rd mem word 0xDEAD with tlast.
//  4 i_regcnt=100, mc=0 -> HDR2 rc field=64; exactly 64 reg reads idx 0..63; 131 words total.
//  5 tready toggled randomly through case 2 -> identical word sequence; o_tdata stable while tvalid&!tready.
//  6 Assert i_rst mid-REG_VAL -> o_tvalid=0 immediately (async); after release, new step yields a fresh HDR0.

Source files
------------

// File: rtl/tracer_stream.sv
// tracer_stream: drains one completed trace step at a time. The step header is
// latched on accept, then the step's register and memory actions are fetched
// from the trace table (1-cycle synchronous read) and serialized as a framed
// 64-bit valid/ready word stream.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. o_tvalid, once high, stays high, and
// o_tdata/o_tlast stay stable, until the word is taken. o_step_ready is high
// exactly in IDLE; a step is taken on i_step_valid & o_step_ready.
module tracer_stream #(
  parameter int TBL_ABITS = 6,
  parameter int TBL_SZ    = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_step_valid,
  output logic                 o_step_ready,
  input  logic [63:0]          i_exec_cnt,
  input  logic [63:0]          i_pc,
  input  logic [31:0]          i_instr,
  input  logic [31:0]          i_regcnt,
  input  logic [31:0]          i_memcnt,
  output logic                 o_rd_reg,
  output logic                 o_rd_mem,
  output logic [TBL_ABITS-1:0] o_rd_idx,
  input  logic [5:0]           i_reg_waddr,
  input  logic [63:0]          i_reg_wres,
  input  logic [5:0]           i_mem_flags,
  input  logic [5:0]           i_mem_regaddr,
  input  logic [63:0]          i_mem_addr,
  input  logic [63:0]          i_mem_data,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic [63:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_step_done,
  output logic [3:0]           o_state
);

  localparam int CW = TBL_ABITS + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TBL_SZ);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, HDR2,
    REG_RD, REG_TAG, REG_VAL,
    MEM_RD, MEM_TAG, MEM_ADDR, MEM_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [TBL_ABITS-1:0] idx_q, idx_d;
  logic [CW-1:0]        rc_q, mc_q;
  logic [63:0]          exec_q, pc_q;
  logic [31:0]          instr_q;
  // cap_q marks the first cycle of a *_TAG state: table data is on the read
  // port then, so the word is built from it before o_tvalid is raised.
  logic                 cap_q, cap_d;
  logic                 cap_reg, cap_mem;
  logic [63:0]          tdata_q, tdata_d;
  logic                 tlast_q, tlast_d;
  logic [63:0]          wres_q, maddr_q, mdata_q;

  logic                 accept, fire, emit;
  logic [CW-1:0]        idx_nx;
  logic [CW-1:0]        rc_in, mc_in;

  assign accept = i_step_valid && (state_q == IDLE);
  assign fire   = o_tvalid && i_tready;
  assign idx_nx = CW'(idx_q) + CW'(1);

  // Action counts above the table size are clamped so indexing stays in range.
  assign rc_in = (i_regcnt > 32'(TBL_SZ)) ? CNT_MAX : i_regcnt[CW-1:0];
  assign mc_in = (i_memcnt > 32'(TBL_SZ)) ? CNT_MAX : i_memcnt[CW-1:0];

  assign emit = (state_q == HDR0) || (state_q == HDR1) || (state_q == HDR2) ||
                (state_q == REG_TAG) || (state_q == REG_VAL) ||
                (state_q == MEM_TAG) || (state_q == MEM_ADDR) || (state_q == MEM_DATA);

  assign o_step_ready = (state_q == IDLE);
  assign o_tvalid     = emit && !cap_q;
  assign o_tdata      = tdata_q;
  assign o_tlast      = tlast_q;
  assign o_rd_reg     = (state_q == REG_RD);
  assign o_rd_mem     = (state_q == MEM_RD);
  assign o_rd_idx     = idx_q;
  assign o_step_done  = fire && tlast_q;
  assign o_state      = state_q;

  // Next-state, index and next output word selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = 1'b0;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    cap_reg = 1'b0;
    cap_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_step_valid) begin
          state_d = HDR0;
          tdata_d = i_exec_cnt;
          tlast_d = 1'b0;
          idx_d   = '0;
        end
      end
      HDR0: begin
        if (fire) begin
          state_d = HDR1;
          tdata_d = pc_q;
        end
      end
      HDR1: begin
        if (fire) begin
          state_d = HDR2;
          tdata_d = {instr_q, 16'(mc_q), 16'(rc_q)};
          tlast_d = (rc_q == '0) && (mc_q == '0);
        end
      end
      HDR2: begin
        if (fire) begin
          idx_d = '0;
          if (tlast_q) begin
            state_d = IDLE;
            tlast_d = 1'b0;
          end else if (rc_q != '0) begin
            state_d = REG_RD;
          end else begin
            state_d = MEM_RD;
          end
        end
      end
      REG_RD: begin
        state_d = REG_TAG;
        cap_d   = 1'b1;
      end
      REG_TAG: begin
        if (cap_q) begin
          cap_reg = 1'b1;
          tdata_d = {8'h52, 50'h0, i_reg_waddr};
        end else if (fire) begin
          state_d = REG_VAL;
          tdata_d = wres_q;
          tlast_d = (idx_nx >= rc_q) && (mc_q == '0);
        end
      end
      REG_VAL: begin
        if (fire) begin
          tlast_d = 1'b0;
          if (idx_nx < rc_q) begin
            state_d = REG_RD;
            idx_d   = idx_nx[TBL_ABITS-1:0];
          end else if (mc_q != '0) begin
            state_d = MEM_RD;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      MEM_RD: begin
        state_d = MEM_TAG;
        cap_d   = 1'b1;
      end
      MEM_TAG: begin
        if (cap_q) begin
          cap_mem = 1'b1;
          tdata_d = {8'h4D, 44'h0, i_mem_flags, i_mem_regaddr};
        end else if (fire) begin
          state_d = MEM_ADDR;
          tdata_d = maddr_q;
        end
      end
      MEM_ADDR: begin
        if (fire) begin
          state_d = MEM_DATA;
          tdata_d = mdata_q;
          tlast_d = (idx_nx >= mc_q);
        end
      end
      MEM_DATA: begin
        if (fire) begin
          tlast_d = 1'b0;
          if (idx_nx < mc_q) begin
            state_d = MEM_RD;
            idx_d   = idx_nx[TBL_ABITS-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output word and latched step/action fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= 1'b0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      rc_q    <= '0;
      mc_q    <= '0;
      exec_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      wres_q  <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      if (accept) begin
        rc_q    <= rc_in;
        mc_q    <= mc_in;
        exec_q  <= i_exec_cnt;
        pc_q    <= i_pc;
        instr_q <= i_instr;
      end
      if (cap_reg) begin
        wres_q <= i_reg_wres;
      end
      if (cap_mem) begin
        maddr_q <= i_mem_addr;
        mdata_q <= i_mem_data;
      end
    end
  end

endmodule
